// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with fill count, programmable
// almost-full / almost-empty thresholds and overflow / underflow pulses.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through: data_out shows the head
//                              word combinationally whenever empty == 0.
//                 undefined -> standard mode: data_out is registered and loads
//                              the head word on the edge of an accepted read.
//
// Parameters:
//   DATA_WIDTH  word width in bits (>= 1)
//   DEPTH       number of entries, power of two (>= 2)
//   AF_LEVEL    almost_full  asserts when count >= AF_LEVEL
//   AE_LEVEL    almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   enable        global qualifier for read and write
//   write         write request, data_in sampled on an accepted write
//   data_in       write data
//   read          read request
//   data_out      read data (registered, or head word in FWFT mode)
//   empty         count == 0
//   full          count == DEPTH
//   almost_empty  count <= AE_LEVEL
//   almost_full   count >= AF_LEVEL
//   count         stored words, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read

module fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        write,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        read,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Storage and pointers; pointers wrap naturally since DEPTH is 2**AW.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // Accept / reject decisions for the current cycle.
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_rej;
    logic          rd_rej;
    logic [CW-1:0] count_next;

    // Next-state flag values, registered below so flags move on the same
    // edge as the operation that changes count.
    logic          empty_next;
    logic          full_next;
    logic          almost_empty_next;
    logic          almost_full_next;

    // Request qualification against the current registered flags.
    always_comb begin
        wr_ok  = enable & write & ~full;
        rd_ok  = enable & read  & ~empty;
        wr_rej = enable & write &  full;
        rd_rej = enable & read  &  empty;
    end

    // Fill count update; simultaneous accepted read and write cancel.
    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Flags derived from the post-edge count.
    always_comb begin
        empty_next        = (count_next == CW'(0));
        full_next         = (count_next == CW'(DEPTH));
        almost_empty_next = (32'(count_next) <= AE_LEVEL);
        almost_full_next  = (32'(count_next) >= AF_LEVEL);
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, count, flags and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            empty        <= empty_next;
            full         <= full_next;
            almost_empty <= almost_empty_next;
            almost_full  <= almost_full_next;
            overflow     <= wr_rej;
            underflow    <= rd_rej;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word shown directly; meaningless while empty.
    assign data_out = mem[rd_ptr];
`else
    // Registered read: load the head word on an accepted read, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=16, DATA_WIDTH=8) with a queue-based
// reference model checked every cycle plus hand-computed expectations.

module tb_fifo_param;

    localparam int DW   = 8;
    localparam int DEP  = 16;
    localparam int AFL  = 14;
    localparam int AEL  = 2;
`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .AF_LEVEL   (AFL),
        .AE_LEVEL   (AEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .write        (write),
        .data_in      (data_in),
        .read         (read),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the last popped word.
    int q[$];
    int m_dout = 0;
    bit m_ovf  = 1'b0;
    bit m_unf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout = 0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit do_w;
            bit do_r;
            do_w  = enable && write && (q.size() < DEP);
            do_r  = enable && read  && (q.size() > 0);
            m_ovf = enable && write && (q.size() == DEP);
            m_unf = enable && read  && (q.size() == 0);
            if (do_r) m_dout = q.pop_front();
            if (do_w) q.push_back(int'(data_in));
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEP));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AEL));
            chk("almost_full", int'(almost_full), int'(q.size() >= AFL));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
            if (FWFT) begin
                if (q.size() > 0) chk("data_out_head", int'(data_out), q[0]);
            end else begin
                chk("data_out", int'(data_out), m_dout);
            end
        end
    end

    // Apply inputs for one clock, return at negedge+1 after that edge.
    task automatic step(input logic e, input logic w, input logic r, input int d);
        enable  = e;
        write   = w;
        read    = r;
        data_in = DW'(d);
        @(negedge clk);
        #1;
    endtask

    // Read one word and check it appears with the mode's latency.
    task automatic pop(input int exp);
        if (FWFT) chk("pop_head", int'(data_out), exp);
        step(1'b1, 1'b0, 1'b1, 0);
        if (!FWFT) chk("pop_data", int'(data_out), exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ovf", int'(overflow), 0);
        if (!FWFT) chk("rst_dout", int'(data_out), 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 0);

        // Fill 0..15.
        for (int i = 0; i < DEP; i++) begin
            step(1'b1, 1'b1, 1'b0, i);
            chk("fill_count", int'(count), i + 1);
            chk("fill_af", int'(almost_full), int'(i + 1 >= 14));
            chk("fill_full", int'(full), int'(i == 15));
        end
        step(1'b1, 1'b1, 1'b0, 99);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("ovf_clear", int'(overflow), 0);

        // Drain 0..15.
        for (int i = 0; i < DEP; i++) begin
            pop(i);
            chk("drain_count", int'(count), 15 - i);
            chk("drain_ae", int'(almost_empty), int'(15 - i <= 2));
            chk("drain_empty", int'(empty), int'(i == 15));
        end
        step(1'b1, 1'b0, 1'b1, 0);
        chk("unf_pulse", int'(underflow), 1);
        if (!FWFT) chk("unf_hold", int'(data_out), 15);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("unf_clear", int'(underflow), 0);

        // Wrap-around.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 200 + i);
        for (int i = 0; i < 10; i++) pop(200 + i);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 100 + i);
        chk("wrap_count", int'(count), 12);
        for (int i = 0; i < 12; i++) pop(100 + i);

        // Simultaneous read/write while empty.
        step(1'b1, 1'b1, 1'b1, 7);
        chk("rw_empty_count", int'(count), 1);
        chk("rw_empty_unf", int'(underflow), 1);
        pop(7);

        // Simultaneous read/write while full: read wins, write rejected.
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b1, 1'b0, 50 + i);
        chk("full_before_rw", int'(full), 1);
        if (FWFT) chk("rw_full_head", int'(data_out), 50);
        step(1'b1, 1'b1, 1'b1, 77);
        if (!FWFT) chk("rw_full_dout", int'(data_out), 50);
        chk("rw_full_count", int'(count), 15);
        chk("rw_full_ovf", int'(overflow), 1);
        chk("rw_full_full", int'(full), 0);

        // Simultaneous read/write at count 5.
        for (int i = 0; i < 10; i++) pop(51 + i);
        chk("mid_count", int'(count), 5);
        step(1'b1, 1'b1, 1'b1, 88);
        chk("rw_mid_count", int'(count), 5);
        chk("rw_mid_ovf", int'(overflow), 0);
        chk("rw_mid_unf", int'(underflow), 0);
        if (!FWFT) chk("rw_mid_dout", int'(data_out), 61);

        // Enable low: nothing moves.
        step(1'b0, 1'b1, 1'b1, 9);
        chk("dis_count", int'(count), 5);
        chk("dis_unf", int'(underflow), 0);
        pop(62); pop(63); pop(64); pop(65); pop(88);
        chk("drained", int'(empty), 1);

        // Async reset mid-burst at count 7, off the clock edge.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 16 + i);
        chk("pre_rst_count", int'(count), 7);
        step(1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_ae", int'(almost_empty), 1);
        chk("arst_af", int'(almost_full), 0);
        if (!FWFT) chk("arst_dout", int'(data_out), 0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 8'h5C);
        chk("post_rst_count", int'(count), 1);
        pop(8'h5C);

`ifdef FIFO_FWFT_EN
        // Fall-through of a single word into an empty FIFO.
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("fwft_show", int'(data_out), 8'hA5);
        chk("fwft_nonempty", int'(empty), 0);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("fwft_hold", int'(data_out), 8'hA5);
        step(1'b1, 1'b0, 1'b1, 0);
        chk("fwft_pop_empty", int'(empty), 1);
`endif

        step(1'b0, 1'b0, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
